// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial_tx / serial_rx link: FSM encodings and
// the clamp helpers that map degenerate frame parameters onto legal ones.
package serial_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2
   } serial_state_t;

   // n0 / n1 of zero would never match a sensible edge, so they behave as 1.
   function automatic logic [31:0] clamp1_32(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

   function automatic logic [7:0] clamp_nbits(input logic [7:0] v, input int unsigned max_w);
      logic [7:0] r;
      r = (v == 8'd0) ? 8'd1 : v;
      if (32'(r) > max_w) begin
         r = 8'(max_w);
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_tx.sv
// Serial transmitter: sends nbits of a word MSB first on y, with every bit edge
// aligned to the shared cnt timebase so the far-end serial_rx samples in step.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter logic P_Y_INIT     = 1'b0,
   parameter int   P_DATA_WIDTH = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [P_DATA_WIDTH-1:0] data,
   input  logic [7:0]              nbits,
   input  logic [31:0]             n0,
   input  logic [31:0]             n1,
   input  logic [31:0]             cnt,
   output logic                    y,
   output logic                    busy,
   output logic                    done
);

   serial_state_t           state_reg;
   logic [P_DATA_WIDTH-1:0] sr_reg;
   logic [7:0]              nbits_reg;
   logic [7:0]              bitcnt_reg;
   logic [31:0]             n0_reg;
   logic [31:0]             n1_reg;
   logic [31:0]             next_edge_reg;

   logic [7:0]              nbits_clamped;
   logic [15:0]             align_shift;
   logic [P_DATA_WIDTH-1:0] sr_load;
   logic                    last_bit;

   // The word is left-aligned at load time so the outgoing bit is always the
   // register MSB; this replaces a wide variable-index mux with one shifter.
   always_comb begin
      nbits_clamped = clamp_nbits(nbits, P_DATA_WIDTH);
      align_shift   = 16'(P_DATA_WIDTH) - 16'(nbits_clamped);
      sr_load       = data << align_shift;
      last_bit      = (bitcnt_reg == (nbits_reg - 8'd1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         y             <= P_Y_INIT;
         busy          <= 1'b0;
         done          <= 1'b0;
         sr_reg        <= '0;
         nbits_reg     <= 8'd1;
         bitcnt_reg    <= 8'd0;
         n0_reg        <= 32'd1;
         n1_reg        <= 32'd1;
         next_edge_reg <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               y    <= P_Y_INIT;
               busy <= 1'b0;
               if (start && !abort) begin
                  sr_reg    <= sr_load;
                  nbits_reg <= nbits_clamped;
                  n0_reg    <= clamp1_32(n0);
                  n1_reg    <= clamp1_32(n1);
                  busy      <= 1'b1;
                  state_reg <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (abort) begin
                  y         <= P_Y_INIT;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (cnt == n0_reg) begin
                  y             <= sr_reg[P_DATA_WIDTH-1];
                  sr_reg        <= sr_reg << 1;
                  next_edge_reg <= n0_reg + n1_reg;
                  bitcnt_reg    <= 8'd0;
                  state_reg     <= ST_SHIFT;
               end else begin
                  y <= P_Y_INIT;
               end
            end

            ST_SHIFT: begin
               if (abort) begin
                  y         <= P_Y_INIT;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (cnt == next_edge_reg) begin
                  if (last_bit) begin
                     y         <= P_Y_INIT;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= ST_IDLE;
                  end else begin
                     y             <= sr_reg[P_DATA_WIDTH-1];
                     sr_reg        <= sr_reg << 1;
                     next_edge_reg <= next_edge_reg + n1_reg;
                     bitcnt_reg    <= bitcnt_reg + 8'd1;
                  end
               end
            end

            default: begin
               y         <= P_Y_INIT;
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
